jserial_alu: RTL and testbench
==============================

JSERIAL_ALU -- requirements
Module: jserial_alu

Interface
REQ-001 Parameter N, default 8, operand width in bits; legal range 2..32.
REQ-002 wclk  in  1  sole clock; all state updates on the rising edge.
REQ-003 wrst_n  in  1  reset, asynchronous, active-low.
REQ-004 wstart  in  1  request to start an operation; sampled only in IDLE.
REQ-005 wop  in  1  operation select: 0 = add, 1 = compare.
REQ-006 wci  in  1  carry-in for add; ignored for compare.
REQ-007 wa  in  N  operand A.
REQ-008 wb  in  N  operand B.
REQ-009 wbusy  out  1  high whenever state is not IDLE.
REQ-010 wdone  out  1  single-cycle pulse when results update.
REQ-011 wsum  out  N  add: A+B+ci (low N bits); compare: A XOR B.
REQ-012 wco  out  1  add: final carry-out; compare: 0.
REQ-013 weq  out  1  compare: A == B; add: 0.
REQ-014 wal  out  1  compare: A > B, unsigned; add: 0.

Function
REQ-015 The block SHALL be a bit-serial unit; its per-bit datapath SHALL be exactly one jadd cell and one jcmp cell, reused every cycle.
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE; transitions are IDLE->RUN, RUN->DONE and DONE->IDLE.
REQ-017 In IDLE, wstart=1 at an edge (edge 0) SHALL latch wa, wb, wop and wci into internal registers, clear the bit counter and enter RUN.
REQ-018 In RUN, each edge k=1..N SHALL process exactly one bit; the counter SHALL advance by 1 per edge and leave RUN after edge N with no off-by-one.
REQ-019 Add SHALL process bits LSB first; the carry register SHALL be initialised to wci, loaded from jadd's wco each bit, and each sum bit shifted into the result register.
REQ-020 Compare SHALL process bits MSB first; the eq register SHALL be initialised to 1 and the al register to 0, both fed through jcmp weqi/wali -> weqo/walo; each jcmp wc bit is the corresponding wsum bit.
REQ-021 At edge N the block SHALL update wsum, wco, weq and wal together and enter DONE; wdone SHALL be 1 for exactly the cycle between edge N and edge N+1.
REQ-022 DONE SHALL return to IDLE at edge N+1 unconditionally; a new start can be accepted at edge N+2 at the earliest.
REQ-023 Outputs wsum, wco, weq and wal SHALL hold their values from one completion to the next, and SHALL NOT change during RUN.
REQ-024 wstart SHALL be ignored in RUN and DONE, with no queuing; changes on wa, wb, wop or wci after edge 0 SHALL NOT affect the operation in flight.
REQ-025 Throughput SHALL be one operation per N+2 cycles with wstart held high.

Reset
REQ-026 wrst_n=0 SHALL immediately force IDLE and clear the counter, operand registers, wsum, wco, weq, wal, wbusy and wdone to 0, independent of wclk.
REQ-027 A reset asserted during RUN or DONE SHALL abort the operation with no wdone pulse; the first edge with wrst_n=1 and wstart=1 SHALL start a fresh operation.

Configuration
REQ-028 Macro JSERIAL_CMP_EN defined: compare is supported as in REQ-020.
REQ-029 Macro JSERIAL_CMP_EN undefined: no jcmp cell or eq/al registers are built; wop is ignored (every operation is an add); weq and wal are tied to 0.

Verification
REQ-030 N=8, add, A=0xFF, B=0x01, ci=0 -> wsum=0x00, wco=1, weq=0, wal=0; wdone is high only in the cycle after edge 8, and wbusy is high from edge 0 to edge 9.
REQ-031 Add, A=0x35, B=0x4A, ci=1 -> wsum=0x80, wco=0; wsum still holds its prior value during RUN.
REQ-032 Compare, A=0x80, B=0x7F -> weq=0, wal=1, wsum=0xFF, wco=0; compare, A=0x5A, B=0x5A -> weq=1, wal=0, wsum=0x00.
REQ-033 wstart held high continuously with changing operands -> starts are accepted only at edges 0, 10, 20, ...; each result matches the operands latched at its start edge.
REQ-034 wrst_n pulsed low after edge 3 of an add -> all outputs 0 at once and no wdone pulse; a following add of 0x01+0x02 gives wsum=0x03.
REQ-035 Build without JSERIAL_CMP_EN, wop=1, A=0x10, B=0x20, ci=0 -> wsum=0x30, weq=0, wal=0.

Source files
------------

// File: rtl/jserial_alu.sv
// Bit-serial add/compare unit: one jadd and one jcmp cell reused per bit.
// Optional macro: JSERIAL_CMP_EN enables compare (wop=1); else add only.
// Ports: wclk/wrst_n clock and async active-low reset; wstart/wop/wci/
// wa/wb request and operands; wbusy/wdone status; wsum/wco/weq/wal results.

module jadd (
  input  logic wa,
  input  logic wb,
  input  logic wci,
  output logic wsum,
  output logic wco
);
  assign wsum = wa ^ wb ^ wci;
  assign wco  = (wa & wb) | (wci & (wa ^ wb));
endmodule

`ifdef JSERIAL_CMP_EN
module jcmp (
  input  logic wa,
  input  logic wb,
  input  logic wc,
  input  logic weqi,
  input  logic wali,
  output logic weqo,
  output logic walo
);
  // wc is a^b; the first differing bit (MSB first) decides ordering
  assign weqo = weqi & ~wc;
  assign walo = wali | (weqi & wa & ~wb);
endmodule
`endif

module jserial_alu #(
  parameter int N = 8
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic         wstart,
  input  logic         wop,
  input  logic         wci,
  input  logic [N-1:0] wa,
  input  logic [N-1:0] wb,
  output logic         wbusy,
  output logic         wdone,
  output logic [N-1:0] wsum,
  output logic         wco,
  output logic         weq,
  output logic         wal
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   res_q, res_d;
  logic           cy_q, cy_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           co_q, co_d;
  logic           weq_q, weq_d;
  logic           wal_q, wal_d;

  logic           op;
  logic [CW-1:0]  idx;
  logic           abit;
  logic           bbit;
  logic           s_sum;
  logic           s_co;
  logic           last;
  logic [N-1:0]   res_nx;

`ifdef JSERIAL_CMP_EN
  logic op_q, op_d;
  logic eq_q, eq_d;
  logic al_q, al_d;
  logic c_eq;
  logic c_al;

  assign op = op_q;

  jcmp u_cmp (
    .wa   (abit),
    .wb   (bbit),
    .wc   (s_sum),
    .weqi (eq_q),
    .wali (al_q),
    .weqo (c_eq),
    .walo (c_al)
  );
`else
  logic unused_op;
  assign unused_op = wop;
  assign op = 1'b0;
`endif

  // add walks LSB first, compare walks MSB first
  assign idx  = op ? (CW'(N-1) - cnt_q) : cnt_q;
  assign abit = a_q[idx];
  assign bbit = b_q[idx];
  assign last = (cnt_q == CW'(N-1));

  // compare forces carry-in 0 so the sum bit is a^b
  jadd u_add (
    .wa   (abit),
    .wb   (bbit),
    .wci  (cy_q & ~op),
    .wsum (s_sum),
    .wco  (s_co)
  );

  assign res_nx = op ? {res_q[N-2:0], s_sum}
                     : {s_sum, res_q[N-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cy_d    = cy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    co_d    = co_q;
    weq_d   = weq_q;
    wal_d   = wal_q;
`ifdef JSERIAL_CMP_EN
    op_d    = op_q;
    eq_d    = eq_q;
    al_d    = al_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (wstart) begin
          a_d     = wa;
          b_d     = wb;
          cy_d    = wci;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef JSERIAL_CMP_EN
          op_d    = wop;
          eq_d    = 1'b1;
          al_d    = 1'b0;
`endif
        end
      end
      RUN: begin
        cy_d  = s_co;
        res_d = res_nx;
        cnt_d = cnt_q + 1'b1;
`ifdef JSERIAL_CMP_EN
        eq_d  = c_eq;
        al_d  = c_al;
`endif
        if (last) begin
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = res_nx;
          co_d    = op ? 1'b0 : s_co;
`ifdef JSERIAL_CMP_EN
          weq_d   = op & c_eq;
          wal_d   = op & c_al;
`else
          weq_d   = 1'b0;
          wal_d   = 1'b0;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      weq_q   <= 1'b0;
      wal_q   <= 1'b0;
`ifdef JSERIAL_CMP_EN
      op_q    <= 1'b0;
      eq_q    <= 1'b0;
      al_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      weq_q   <= weq_d;
      wal_q   <= wal_d;
`ifdef JSERIAL_CMP_EN
      op_q    <= op_d;
      eq_q    <= eq_d;
      al_q    <= al_d;
`endif
    end
  end

  assign wbusy = busy_q;
  assign wdone = done_q;
  assign wsum  = sum_q;
  assign wco   = co_q;
  assign weq   = weq_q;
  assign wal   = wal_q;

endmodule

// File: tb/tb_jserial_alu.sv
// Directed bench for jserial_alu with a result scoreboard.
// Expected results come from a behavioural model of add/compare.

module tb_jserial_alu;

  localparam int N = 8;

  logic         wclk = 1'b0;
  logic         wrst_n = 1'b0;
  logic         wstart = 1'b0;
  logic         wop = 1'b0;
  logic         wci = 1'b0;
  logic [N-1:0] wa = '0;
  logic [N-1:0] wb = '0;
  logic         wbusy;
  logic         wdone;
  logic [N-1:0] wsum;
  logic         wco;
  logic         weq;
  logic         wal;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         co;
    logic         eq;
    logic         al;
  } res_t;

  res_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] last_sum = '0;

  jserial_alu #(.N(N)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wstart (wstart),
    .wop    (wop),
    .wci    (wci),
    .wa     (wa),
    .wb     (wb),
    .wbusy  (wbusy),
    .wdone  (wdone),
    .wsum   (wsum),
    .wco    (wco),
    .weq    (weq),
    .wal    (wal)
  );

  always #5 wclk = ~wclk;

  function automatic res_t model(logic op, logic [N-1:0] a,
                                 logic [N-1:0] b, logic ci);
    res_t     r;
    logic [N:0] s;
    r = '0;
`ifdef JSERIAL_CMP_EN
    if (op) begin
      r.sum = a ^ b;
      r.eq  = (a == b);
      r.al  = (a > b);
      return r;
    end
`else
    r.eq = op & 1'b0;
`endif
    s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    r.sum = s[N-1:0];
    r.co  = s[N];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop one expected result per wdone pulse
  always @(negedge wclk) begin
    res_t e;
    if (wrst_n && wdone) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(wdone), 32'd0);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(wsum), 32'(e.sum));
        chk("co", 32'(wco), 32'(e.co));
        chk("eq", 32'(weq), 32'(e.eq));
        chk("al", 32'(wal), 32'(e.al));
        last_sum = e.sum;
      end
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, 32'(wbusy), 32'd0);
    chk({tag, "_done"}, 32'(wdone), 32'd0);
    chk({tag, "_sum"}, 32'(wsum), 32'd0);
    chk({tag, "_co"}, 32'(wco), 32'd0);
    chk({tag, "_eq"}, 32'(weq), 32'd0);
    chk({tag, "_al"}, 32'(wal), 32'd0);
  endtask

  task automatic run_op(logic op, logic [N-1:0] a,
                        logic [N-1:0] b, logic ci);
    wop = op;
    wa = a;
    wb = b;
    wci = ci;
    wstart = 1'b1;
    q.push_back(model(op, a, b, ci));
    @(posedge wclk);
    #1;
    wstart = 1'b0;
    wa = N'($urandom);
    wb = N'($urandom);
    wop = 1'($urandom);
    wci = 1'($urandom);
    chk("busy_e0", 32'(wbusy), 32'd1);
    chk("done_e0", 32'(wdone), 32'd0);
    for (int k = 1; k <= N; k++) begin
      @(posedge wclk);
      #1;
      chk("busy_run", 32'(wbusy), 32'd1);
      if (k < N) begin
        chk("done_run", 32'(wdone), 32'd0);
        chk("sum_hold", 32'(wsum), 32'(last_sum));
      end else begin
        chk("done_eN", 32'(wdone), 32'd1);
      end
    end
    @(posedge wclk);
    #1;
    chk("busy_eN1", 32'(wbusy), 32'd0);
    chk("done_eN1", 32'(wdone), 32'd0);
  endtask

  initial begin
    #1;
    chk_zero("rst");
    @(negedge wclk);
    wrst_n = 1'b1;
    @(negedge wclk);

    run_op(1'b0, 8'hFF, 8'h01, 1'b0);
    run_op(1'b0, 8'h35, 8'h4A, 1'b1);
    run_op(1'b1, 8'h80, 8'h7F, 1'b0);
    run_op(1'b1, 8'h5A, 8'h5A, 1'b0);
    run_op(1'b1, 8'h10, 8'h20, 1'b0);
    run_op(1'b0, 8'hC3, 8'h3C, 1'b1);
    run_op(1'b1, 8'h01, 8'h02, 1'b0);

    // back-to-back starts with wstart held high
    wstart = 1'b1;
    wop = 1'b0;
    wa = 8'h11;
    wb = 8'h22;
    wci = 1'b1;
    for (int j = 0; j < 30; j++) begin
      if (j % 10 == 0) q.push_back(model(wop, wa, wb, wci));
      @(posedge wclk);
      #1;
      chk("tp_busy", 32'(wbusy), (j % 10 == 9) ? 32'd0 : 32'd1);
      if (j == 20) wstart = 1'b0;
      wa = N'($urandom);
      wb = N'($urandom);
      wop = 1'($urandom);
      wci = 1'($urandom);
    end

    run_op(1'b0, 8'h12, 8'h34, 1'b0);

    // abort an add mid-flight
    wop = 1'b0;
    wa = 8'h0F;
    wb = 8'h01;
    wci = 1'b0;
    wstart = 1'b1;
    @(posedge wclk);
    #1;
    wstart = 1'b0;
    repeat (3) @(posedge wclk);
    #1;
    wrst_n = 1'b0;
    #1;
    chk_zero("abort");
    last_sum = '0;
    repeat (3) begin
      @(negedge wclk);
      chk("abort_done", 32'(wdone), 32'd0);
    end
    wrst_n = 1'b1;
    run_op(1'b0, 8'h01, 8'h02, 1'b0);

    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
